// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - req/ack data-memory port between the memory stage and data memory
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [63:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline memory stage: 64-bit ld/sd over req/ack with timeout and writeback register
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ex_valid,
    input  logic [63:0]         alu_result,
    input  logic [63:0]         read_data2,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic                MemtoReg,
    input  logic                RegWrite,
    input  logic [4:0]          rd,
    output logic                stall,
    mem_access_stage_if.master  dmem,
    output logic                wb_valid,
    output logic [63:0]         wb_data,
    output logic [4:0]          wb_rd,
    output logic                wb_regwrite,
    output logic                mem_fault
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [63:0]        addr_q, addr_d;
    logic [63:0]        wdata_q, wdata_d;
    logic [4:0]         rd_lat_q, rd_lat_d;
    logic               regwrite_lat_q, regwrite_lat_d;
    logic               memtoreg_q, memtoreg_d;
    logic               wb_valid_q, wb_valid_d;
    logic [63:0]        wb_data_q, wb_data_d;
    logic [4:0]         wb_rd_q, wb_rd_d;
    logic               wb_regwrite_q, wb_regwrite_d;
    logic               mem_fault_q, mem_fault_d;

    logic               is_mem;
    logic               bad_op;

    // A memory op is illegal if both directions are requested or the address is not doubleword aligned.
    assign is_mem = MemRead | MemWrite;
    assign bad_op = (MemRead & MemWrite) | (is_mem & (alu_result[2:0] != 3'b000));

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        req_d          = req_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rd_lat_d       = rd_lat_q;
        regwrite_lat_d = regwrite_lat_q;
        memtoreg_d     = memtoreg_q;
        wb_valid_d     = 1'b0;
        wb_data_d      = wb_data_q;
        wb_rd_d        = wb_rd_q;
        wb_regwrite_d  = wb_regwrite_q;
        mem_fault_d    = mem_fault_q;

        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (!is_mem) begin
                        wb_valid_d    = 1'b1;
                        wb_data_d     = alu_result;
                        wb_rd_d       = rd;
                        wb_regwrite_d = RegWrite;
                        mem_fault_d   = 1'b0;
                    end else if (bad_op) begin
                        wb_valid_d    = 1'b1;
                        wb_data_d     = alu_result;
                        wb_rd_d       = rd;
                        wb_regwrite_d = 1'b0;
                        mem_fault_d   = 1'b1;
                    end else begin
                        addr_d         = alu_result;
                        wdata_d        = read_data2;
                        we_d           = MemWrite;
                        rd_lat_d       = rd;
                        regwrite_lat_d = RegWrite;
                        memtoreg_d     = MemtoReg;
                        req_d          = 1'b1;
                        cnt_d          = '0;
                        state_d        = ACCESS;
                    end
                end
            end

            ACCESS: begin
                // Ack takes priority over the timeout when both land in the same cycle.
                if (dmem.dmem_ack) begin
                    req_d         = 1'b0;
                    wb_valid_d    = 1'b1;
                    wb_data_d     = memtoreg_q ? dmem.dmem_rdata : addr_q;
                    wb_rd_d       = rd_lat_q;
                    wb_regwrite_d = regwrite_lat_q & ~we_q;
                    mem_fault_d   = 1'b0;
                    state_d       = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    req_d         = 1'b0;
                    wb_valid_d    = 1'b1;
                    wb_data_d     = addr_q;
                    wb_rd_d       = rd_lat_q;
                    wb_regwrite_d = 1'b0;
                    mem_fault_d   = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rd_lat_q       <= '0;
            regwrite_lat_q <= 1'b0;
            memtoreg_q     <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_data_q      <= '0;
            wb_rd_q        <= '0;
            wb_regwrite_q  <= 1'b0;
            mem_fault_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            req_q          <= req_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            rd_lat_q       <= rd_lat_d;
            regwrite_lat_q <= regwrite_lat_d;
            memtoreg_q     <= memtoreg_d;
            wb_valid_q     <= wb_valid_d;
            wb_data_q      <= wb_data_d;
            wb_rd_q        <= wb_rd_d;
            wb_regwrite_q  <= wb_regwrite_d;
            mem_fault_q    <= mem_fault_d;
        end
    end

    assign stall           = (state_q == ACCESS);
    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign wb_valid        = wb_valid_q;
    assign wb_data         = wb_data_q;
    assign wb_rd           = wb_rd_q;
    assign wb_regwrite     = wb_regwrite_q;
    assign mem_fault       = mem_fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed and randomized bench for mem_access_stage against an op-level model
module tb_mem_access_stage;
    localparam int TIMEOUT = 16;
    localparam int NO_ACK  = -1;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [63:0] alu_result;
    logic [63:0] read_data2;
    logic        MemRead;
    logic        MemWrite;
    logic        MemtoReg;
    logic        RegWrite;
    logic [4:0]  rd;
    logic        stall;
    logic        wb_valid;
    logic [63:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic        mem_fault;

    int n_cmp = 0;
    int n_err = 0;

    mem_access_stage_if dmem_if ();

    mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .ex_valid    (ex_valid),
        .alu_result  (alu_result),
        .read_data2  (read_data2),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .rd          (rd),
        .stall       (stall),
        .dmem        (dmem_if.master),
        .wb_valid    (wb_valid),
        .wb_data     (wb_data),
        .wb_rd       (wb_rd),
        .wb_regwrite (wb_regwrite),
        .mem_fault   (mem_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_quiet(input string tag);
        check({tag, ".wb_valid"}, 64'(wb_valid), 64'd0);
        check({tag, ".stall"}, 64'(stall), 64'd0);
        check({tag, ".req"}, 64'(dmem_if.dmem_req), 64'd0);
    endtask

    // Issues one op from IDLE and checks its whole life against the op-level rules.
    // ack_at is the 0-based ACCESS cycle in which ack is raised, or NO_ACK.
    task automatic run_op(input logic mr, input logic mw, input logic m2r, input logic rw,
                          input logic [4:0] r, input logic [63:0] a, input logic [63:0] d,
                          input int ack_at, input logic [63:0] rdat);
        bit is_mem;
        bit bad;
        bit done;
        is_mem = mr || mw;
        bad    = is_mem && ((mr && mw) || (a[2:0] != 3'b000));

        ex_valid = 1'b1; MemRead = mr; MemWrite = mw; MemtoReg = m2r;
        RegWrite = rw; rd = r; alu_result = a; read_data2 = d;
        step();
        ex_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        alu_result = {$urandom, $urandom}; read_data2 = {$urandom, $urandom};
        rd = 5'($urandom);

        if (!is_mem) begin
            check("alu.wb_valid", 64'(wb_valid), 64'd1);
            check("alu.wb_data", wb_data, a);
            check("alu.wb_rd", 64'(wb_rd), 64'(r));
            check("alu.wb_regwrite", 64'(wb_regwrite), 64'(rw));
            check("alu.mem_fault", 64'(mem_fault), 64'd0);
            check("alu.req", 64'(dmem_if.dmem_req), 64'd0);
            check("alu.stall", 64'(stall), 64'd0);
        end else if (bad) begin
            check("bad.wb_valid", 64'(wb_valid), 64'd1);
            check("bad.mem_fault", 64'(mem_fault), 64'd1);
            check("bad.wb_regwrite", 64'(wb_regwrite), 64'd0);
            check("bad.req", 64'(dmem_if.dmem_req), 64'd0);
            check("bad.stall", 64'(stall), 64'd0);
        end else begin
            done = 1'b0;
            for (int k = 0; k < TIMEOUT && !done; k++) begin
                check("acc.stall", 64'(stall), 64'd1);
                check("acc.req", 64'(dmem_if.dmem_req), 64'd1);
                check("acc.we", 64'(dmem_if.dmem_we), 64'(mw));
                check("acc.addr", dmem_if.dmem_addr, a);
                if (mw) check("acc.wdata", dmem_if.dmem_wdata, d);
                check("acc.wb_valid", 64'(wb_valid), 64'd0);
                if (k == ack_at) begin
                    dmem_if.dmem_ack = 1'b1;
                    dmem_if.dmem_rdata = rdat;
                end
                step();
                dmem_if.dmem_ack = 1'b0;
                dmem_if.dmem_rdata = {$urandom, $urandom};
                if (k == ack_at) begin
                    check("ack.wb_valid", 64'(wb_valid), 64'd1);
                    check("ack.mem_fault", 64'(mem_fault), 64'd0);
                    check("ack.wb_data", wb_data, m2r ? rdat : a);
                    check("ack.wb_rd", 64'(wb_rd), 64'(r));
                    check("ack.wb_regwrite", 64'(wb_regwrite), 64'(rw && !mw));
                    check("ack.req", 64'(dmem_if.dmem_req), 64'd0);
                    check("ack.stall", 64'(stall), 64'd0);
                    done = 1'b1;
                end else if (k == TIMEOUT - 1) begin
                    check("tmo.wb_valid", 64'(wb_valid), 64'd1);
                    check("tmo.mem_fault", 64'(mem_fault), 64'd1);
                    check("tmo.wb_regwrite", 64'(wb_regwrite), 64'd0);
                    check("tmo.req", 64'(dmem_if.dmem_req), 64'd0);
                    check("tmo.stall", 64'(stall), 64'd0);
                    done = 1'b1;
                end
            end
            check("acc.retired", 64'(done), 64'd1);
        end
        step();
        check_idle_quiet("post");
    endtask

    task automatic stray_ack();
        dmem_if.dmem_ack = 1'b1;
        dmem_if.dmem_rdata = {$urandom, $urandom};
        step();
        dmem_if.dmem_ack = 1'b0;
        check_idle_quiet("stray");
        step();
        check_idle_quiet("stray2");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ex_valid = 1'b0; alu_result = '0; read_data2 = '0;
        MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0; rd = '0;
        dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = '0;
        step(); step();
        check("rst.req", 64'(dmem_if.dmem_req), 64'd0);
        check("rst.we", 64'(dmem_if.dmem_we), 64'd0);
        check("rst.addr", dmem_if.dmem_addr, 64'd0);
        check("rst.wdata", dmem_if.dmem_wdata, 64'd0);
        check("rst.wb_valid", 64'(wb_valid), 64'd0);
        check("rst.wb_data", wb_data, 64'd0);
        check("rst.wb_rd", 64'(wb_rd), 64'd0);
        check("rst.wb_regwrite", 64'(wb_regwrite), 64'd0);
        check("rst.mem_fault", 64'(mem_fault), 64'd0);
        check("rst.stall", 64'(stall), 64'd0);
        reset = 1'b0;
        step();

        run_op(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 64'h2A, 64'h0, NO_ACK, 64'h0);
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 64'h100, 64'h0, 2, 64'hDEADBEEF);
        run_op(1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 64'h108, 64'h55, 0, 64'h0);
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 64'h10C, 64'h0, NO_ACK, 64'h0);
        run_op(1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 64'h110, 64'h0, NO_ACK, 64'h0);
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 64'h200, 64'h0, NO_ACK, 64'h0);
        stray_ack();
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 64'h208, 64'h0, TIMEOUT - 1, 64'h1234_5678_9ABC_DEF0);

        // Reset on the second ACCESS cycle, late ack afterwards.
        ex_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; MemtoReg = 1'b1;
        RegWrite = 1'b1; rd = 5'd11; alu_result = 64'h300;
        step();
        ex_valid = 1'b0; MemRead = 1'b0;
        check("rma.stall", 64'(stall), 64'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        dmem_if.dmem_ack = 1'b1; dmem_if.dmem_rdata = 64'hBAD;
        check_idle_quiet("rma");
        step();
        dmem_if.dmem_ack = 1'b0;
        check_idle_quiet("rma.late");
        step();
        check_idle_quiet("rma.after");

        for (int i = 0; i < 60; i++) begin
            int sel;
            int ack_at;
            logic [63:0] a;
            logic mr, mw;
            sel = int'($urandom_range(0, 9));
            a = {$urandom, $urandom};
            a[2:0] = 3'b000;
            mr = 1'b0; mw = 1'b0;
            case (sel)
                0, 1:    ;
                2, 3, 4: mr = 1'b1;
                5, 6, 7: mw = 1'b1;
                8: begin mr = 1'b1; a[2:0] = 3'($urandom_range(1, 7)); end
                default: begin mr = 1'b1; mw = 1'b1; end
            endcase
            case ($urandom_range(0, 11))
                0:       ack_at = NO_ACK;
                1:       ack_at = TIMEOUT - 1;
                default: ack_at = int'($urandom_range(0, 5));
            endcase
            run_op(mr, mw, 1'($urandom), 1'($urandom), 5'($urandom), a,
                   {$urandom, $urandom}, ack_at, {$urandom, $urandom});
            if ($urandom_range(0, 7) == 0) stray_ack();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
